// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single-port registered RAM: master 0 (CPU)
// and master 1 (screen fill/DMA), with round-robin or starvation-escalated fixed priority.
module ram_arbiter #(
    parameter int WIDTH      = 16,
    parameter int ADDR_W     = 15,
    parameter int FIXED_PRIO = 0,
    parameter int MAX_WAIT   = 8
) (
    input  logic              CPUclk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [WIDTH-1:0]  m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [WIDTH-1:0]  m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [WIDTH-1:0]  m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [WIDTH-1:0]  m1_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [WIDTH-1:0]  ram_wdata,
    output logic              ram_we,
    input  logic [WIDTH-1:0]  ram_rdata
);

    localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

    logic       lastGnt_q, lastGnt_d;
    logic [7:0] waitCnt_q, waitCnt_d;
    logic       rdValid0_q, rdValid0_d;
    logic       rdValid1_q, rdValid1_d;
    logic       gnt0, gnt1;

    // lastGnt_q holds the index of the most recently granted master
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (m0_req && m1_req) begin
                if (FIXED_PRIO != 0) begin
                    if (waitCnt_q == MaxWait) gnt1 = 1'b1;
                    else                      gnt0 = 1'b1;
                end else if (lastGnt_q) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        if (gnt0) begin
            ram_addr  = m0_addr;
            ram_wdata = m0_wdata;
            ram_we    = m0_we;
        end else if (gnt1) begin
            ram_addr  = m1_addr;
            ram_wdata = m1_wdata;
            ram_we    = m1_we;
        end
    end

    always_comb begin
        lastGnt_d = lastGnt_q;
        if (gnt0)      lastGnt_d = 1'b0;
        else if (gnt1) lastGnt_d = 1'b1;

        waitCnt_d = '0;
        if (FIXED_PRIO != 0 && m1_req && !gnt1) begin
            waitCnt_d = (waitCnt_q == MaxWait) ? waitCnt_q : waitCnt_q + 8'd1;
        end

        rdValid0_d = gnt0 && !m0_we;
        rdValid1_d = gnt1 && !m1_we;
    end

    always_ff @(posedge CPUclk) begin
        if (rst) begin
            lastGnt_q  <= 1'b1;
            waitCnt_q  <= '0;
            rdValid0_q <= 1'b0;
            rdValid1_q <= 1'b0;
        end else begin
            lastGnt_q  <= lastGnt_d;
            waitCnt_q  <= waitCnt_d;
            rdValid0_q <= rdValid0_d;
            rdValid1_q <= rdValid1_d;
        end
    end

    // Masking with rst drops a read whose data would land in the first reset cycle
    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_rvalid = rdValid0_q && !rst;
    assign m1_rvalid = rdValid1_q && !rst;
    assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
    assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

endmodule
